// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the data_memory request interface. It accepts a
//   level-held read or write request from the CPU-side initiator and services it
//   against an internal word-addressed SRAM after a fixed latency. It then
//   returns a one-cycle data_good strobe, with read data for reads.
//
//   Parameters
//     DEPTH    number of 32-bit words in the backing store (power of 2, >= 4)
//     LATENCY  cycles from the first request cycle to the data_good cycle (>= 1)
//
//   Ports
//     clk           in   system clock, rising edge
//     nrst          in   asynchronous active-low reset
//     data_read     in   read request, held until data_good
//     data_write    in   write request, held until data_good
//     data_adr_i    in   byte address; bits [1:0] are ignored
//     data_wdata_i  in   write data
//     data_rdata_o  out  read data, updated only by read commits
//     data_good     out  one-cycle response strobe
//     busy          out  transaction in flight
//     err           out  pulses with data_good for an out-of-range address
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_good,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int          CNT_INIT_I = (LATENCY > 1) ? (int'(LATENCY) - 2) : 0;
  localparam logic [CW-1:0] CNT_INIT = CNT_INIT_I[CW-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // With a single-cycle latency the BUSY phase is skipped entirely.
  localparam state_e ACCEPT_ST = (LATENCY == 1) ? ST_RESP : ST_BUSY;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_rd_q, op_rd_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          good_q, good_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic accept_s;
  logic commit_s;
  logic mem_we_s;
  logic unused_adr_s;

  assign unused_adr_s = ^data_adr_i[1:0];

  // State register and request latch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      op_rd_q    <= 1'b0;
      idx_q      <= {AW{1'b0}};
      in_range_q <= 1'b0;
      wdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_rd_q    <= op_rd_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_read || data_write) begin
          accept_s = 1'b1;
          state_d  = ACCEPT_ST;
          cnt_d    = CNT_INIT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        // Initiator still holds its request here; never re-accept it.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output and commit logic. The *_d request fields already equal the live
  // inputs in the accepting cycle, so a LATENCY==1 commit straight from IDLE
  // uses the same path as a commit from BUSY.
  always_comb begin
    op_rd_d    = op_rd_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    wdata_d    = wdata_q;
    if (accept_s) begin
      op_rd_d    = data_read;
      idx_d      = data_adr_i[AW+1:2];
      in_range_d = (data_adr_i[31:AW+2] == '0);
      wdata_d    = data_wdata_i;
    end else begin
      op_rd_d    = op_rd_q;
    end

    commit_s = (state_d == ST_RESP) && (state_q != ST_RESP);
    mem_we_s = commit_s && !op_rd_d && in_range_d;

    rdata_d = rdata_q;
    if (commit_s && op_rd_d) begin
      rdata_d = in_range_d ? mem_q[idx_d] : 32'h0000_0000;
    end else begin
      rdata_d = rdata_q;
    end

    if (commit_s) begin
      err_d = !in_range_d;
    end else if (state_q == ST_RESP) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    good_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_q <= 32'h0000_0000;
      good_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      good_q  <= good_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Backing store; cleared by reset, written only on an in-range write commit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (mem_we_s) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign data_rdata_o = rdata_q;
  assign data_good    = good_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
